fifo_drain_packetizer: RTL and testbench

FIFO_DRAIN_PACKETIZER -- requirements
Module: fifo_drain_packetizer

---
 rtl/fifo_drain_packetizer.sv | 152 +++++++++++++++
 tb/tb_fifo_drain_packetizer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_packetizer.sv
// Drains an upstream sync FIFO into a header-prefixed packet stream.
// Payload words pass through a 2-entry skid whose head drives m_data.
module fifo_drain_packetizer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_last,
  output logic [7:0]            pkt_seq
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } state_t;

  localparam logic [8:0] LEN    = 9'(PKT_LEN);
  localparam logic [8:0] LEN_M1 = 9'(PKT_LEN - 1);

  state_t                state_q, state_d;
  logic [FIFO_WIDTH-1:0] slot0_q, slot0_d;
  logic [FIFO_WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rd_pend_q;
  logic [8:0]            rcnt_q, rcnt_d;
  logic [8:0]            wcnt_q, wcnt_d;
  logic [7:0]            seq_q, seq_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  last_q, last_d;
  logic                  in_pay;
  logic                  pay_pop;
  logic [2:0]            credit;
  logic [FIFO_WIDTH-1:0] hdr;

  assign in_pay  = (state_q == PAYLOAD);
  assign pay_pop = in_pay && valid_q && m_ready;
  // Skid entries still held after this cycle's pop, plus the read in flight.
  assign credit  = 3'(occ_q) + 3'(rd_pend_q) - 3'(pay_pop);
  assign hdr     = FIFO_WIDTH'({8'hA5, seq_q});

  assign fifo_rd_en = !rst && in_pay && !fifo_empty
                      && (rcnt_q < LEN) && (credit < 3'd2);

  assign m_data  = slot0_q;
  assign m_valid = valid_q;
  assign m_sop   = sop_q;
  assign m_last  = last_q;
  assign pkt_seq = seq_q;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    seq_d   = seq_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = HDR;
          slot0_d = hdr;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          last_d  = 1'b0;
        end
      end
      HDR: begin
        if (valid_q && m_ready) begin
          state_d = PAYLOAD;
          seq_d   = seq_q + 8'd1;
          valid_d = 1'b0;
          sop_d   = 1'b0;
        end
      end
      PAYLOAD: begin
        occ_d  = credit[1:0];
        rcnt_d = rcnt_q + 9'(fifo_rd_en);
        wcnt_d = wcnt_q + 9'(pay_pop);
        unique case ({pay_pop, rd_pend_q})
          2'b11: begin
            if (occ_q == 2'd2) begin
              slot0_d = slot1_q;
              slot1_d = fifo_dout;
            end else begin
              slot0_d = fifo_dout;
            end
          end
          2'b10: slot0_d = slot1_q;
          2'b01: begin
            if (occ_q == 2'd0) slot0_d = fifo_dout;
            else               slot1_d = fifo_dout;
          end
          default: ;
        endcase
        valid_d = (occ_d != 2'd0);
        last_d  = valid_d && (wcnt_d == LEN_M1);
        if (pay_pop && last_q) begin
          state_d = IDLE;
          occ_d   = 2'd0;
          rcnt_d  = '0;
          wcnt_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot0_q   <= '0;
      slot1_q   <= '0;
      occ_q     <= '0;
      rd_pend_q <= 1'b0;
      rcnt_q    <= '0;
      wcnt_q    <= '0;
      seq_q     <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      occ_q     <= occ_d;
      rd_pend_q <= fifo_rd_en;
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
      seq_q     <= seq_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_packetizer.sv
// Directed bench for fifo_drain_packetizer with a registered-output
// FIFO model and a beat monitor sampling on the falling edge.
module tb_fifo_drain_packetizer;

  localparam int W = 16;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_dout = '0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_sop;
  logic         m_last;
  logic [7:0]   pkt_seq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc    = 0;

  typedef struct packed {
    logic        sop;
    logic        last;
    logic [15:0] data;
  } beat_t;

  beat_t beats [$];
  int    bcyc  [$];

  fifo_drain_packetizer #(
    .FIFO_WIDTH(W),
    .PKT_LEN   (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sop     (m_sop),
    .m_last    (m_last),
    .pkt_seq   (pkt_seq)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[12'(rd_ptr)];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic        st_q  = 1'b0;
  logic [17:0] st_b  = '0;
  int          rd_n  = 0;
  int          pay_n = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_n  = 0;
      pay_n = 0;
      st_q  = 1'b0;
    end else begin
      if (st_q) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_hold", 32'({m_sop, m_last, m_data}), 32'(st_b));
      end
      if (m_valid && m_sop)
        chk("hdr_no_rd", 32'(fifo_rd_en), 32'd0);
      if (fifo_rd_en) begin
        chk("rd_credit",
            32'((rd_n - pay_n - ((m_valid && m_ready && !m_sop) ? 1 : 0)) < 2),
            32'd1);
        rd_n++;
      end
      if (m_valid && m_ready) begin
        beats.push_back({m_sop, m_last, m_data});
        bcyc.push_back(cyc);
        if (!m_sop) pay_n++;
      end
      st_q = m_valid && !m_ready;
      st_b = {m_sop, m_last, m_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[12'(wr_ptr)] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    beats.delete();
    bcyc.delete();
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (beats.size() < n)
      chk({tag, "_timeout"}, 32'(beats.size()), 32'(n));
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] seq,
                            input logic [15:0] base);
    beat_t b;
    for (int j = 0; j <= N; j++) begin
      if (beats.size() == 0) begin
        b = '1;
      end else begin
        b = beats.pop_front();
        bcyc.delete(0);
      end
      if (j == 0)
        chk({tag, "_hdr"}, 32'(b), 32'({1'b1, 1'b0, 8'hA5, seq}));
      else
        chk({tag, "_pay"}, 32'(b),
            32'({1'b0, (j == N), base + 16'(j - 1)}));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    beat_t b;
    int    k;

    tick();
    tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_sop", 32'(m_sop), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_seq", 32'(pkt_seq), 32'd0);
    chk("rst_rd", 32'(fifo_rd_en), 32'd0);
    rst = 1'b0;

    // basic packet, full throughput
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    wait_beats("s1", 9, 100);
    if (bcyc.size() >= 9) begin
      chk("s1_lat", 32'(bcyc[1] - bcyc[0]), 32'd3);
      chk("s1_burst", 32'(bcyc[8] - bcyc[1]), 32'd7);
    end
    expect_pkt("s1", 8'd0, 16'h0001);
    tick();
    chk("s1_seq", 32'(pkt_seq), 32'd1);

    // header held under backpressure
    m_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) push(16'h0600 + 16'(i));
    k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    repeat (10) begin
      chk("s6_valid", 32'(m_valid), 32'd1);
      chk("s6_data", 32'(m_data), 32'hA500);
      chk("s6_rd", 32'(fifo_rd_en), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    wait_beats("s6", 9, 100);
    expect_pkt("s6", 8'd0, 16'h0601);

    // ready toggling every cycle over two packets
    do_reset();
    for (int i = 1; i <= 16; i++) push(16'h0300 + 16'(i));
    k = 0;
    while (k < 400 && beats.size() < 18) begin
      tick();
      m_ready = ~m_ready;
      k++;
    end
    m_ready = 1'b1;
    wait_beats("s2", 18, 50);
    expect_pkt("s2a", 8'd0, 16'h0301);
    expect_pkt("s2b", 8'd1, 16'h0309);

    // FIFO underrun mid-packet
    do_reset();
    for (int i = 1; i <= 3; i++) push(16'h0400 + 16'(i));
    wait_beats("s3a", 4, 50);
    repeat (17) begin
      chk("s3_gap_valid", 32'(m_valid), 32'd0);
      chk("s3_gap_last", 32'(m_last), 32'd0);
      tick();
    end
    chk("s3_seq", 32'(pkt_seq), 32'd1);
    for (int i = 4; i <= 8; i++) push(16'h0400 + 16'(i));
    wait_beats("s3", 9, 50);
    expect_pkt("s3", 8'd0, 16'h0401);

    // reset during payload word 4 with a read in flight
    do_reset();
    for (int i = 1; i <= 21; i++) push(16'h0100 + 16'(i));
    k = 0;
    while (!(m_valid && m_data == 16'h0104) && k < 50) begin
      tick();
      k++;
    end
    chk("s5_reach", 32'(m_data), 32'h0104);
    rst = 1'b1;
    #1;
    chk("s5_rd_comb", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    chk("s5_valid", 32'(m_valid), 32'd0);
    chk("s5_seq", 32'(pkt_seq), 32'd0);
    chk("s5_pre_n", 32'(beats.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (beats.size() == 0) begin
        b = '1;
      end else begin
        b = beats.pop_front();
        bcyc.delete(0);
      end
      if (j == 0)
        chk("s5_pre_hdr", 32'(b), 32'({2'b10, 16'hA500}));
      else
        chk("s5_pre_pay", 32'(b), 32'({2'b00, 16'h0100 + 16'(j)}));
    end
    wait_beats("s5", 18, 100);
    expect_pkt("s5a", 8'd0, 16'h0106);
    expect_pkt("s5b", 8'd1, 16'h010E);

    // 257 packets for sequence wrap
    do_reset();
    for (int i = 0; i < 257 * N; i++) push(16'(i));
    wait_beats("s4", 257 * (N + 1), 8000);
    for (int p = 0; p < 257; p++)
      expect_pkt("s4", 8'(p), 16'(p * N));
    chk("s4_seq", 32'(pkt_seq), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
